// File: rtl/result_piso.sv
// result_piso: PE-array result unloader, parallel load to one lane per cycle over valid/ready,
// with a one-deep shadow register; RESULT_PISO_LAST_EN adds the s_out_last output.
`ifndef PE_NUM
`define PE_NUM 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
module result_piso #(
    parameter int PE_NUM     = `PE_NUM,
    parameter int DATA_WIDTH = `DATA_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load,
    input  logic [PE_NUM*2*DATA_WIDTH-1:0] p_in,
    input  logic                           s_out_ready,
    output logic                           s_out_v,
    output logic [2*DATA_WIDTH-1:0]        s_out,
    output logic                           busy,
    output logic                           overflow
`ifdef RESULT_PISO_LAST_EN
    ,
    output logic                           s_out_last
`endif
);
    localparam int W = 2*DATA_WIDTH;
    localparam int IW = PE_NUM > 1 ? $clog2(PE_NUM) : 1;
    localparam logic [IW-1:0] LAST = IW'(PE_NUM-1);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state_q, state_d;
    logic [PE_NUM*W-1:0] sreg_q, sreg_d, shd_q, shd_d;
    logic [IW-1:0] idx_q, idx_d;
    logic shd_full_q, shd_full_d, ovf_d, hs, last_hs;
    logic v_q, busy_q, ovf_q;
    logic [W-1:0] s_out_q, lane_d;
    always_comb begin
        hs = (state_q == SHIFT) && s_out_ready;
        last_hs = hs && (idx_q == LAST);
        state_d = state_q;
        sreg_d = sreg_q;
        shd_d = shd_q;
        idx_d = idx_q;
        shd_full_d = shd_full_q;
        ovf_d = 1'b0;
        if (state_q == IDLE) begin
            if (load) begin
                sreg_d = p_in;
                idx_d = '0;
                state_d = SHIFT;
            end
        end else begin
            if (hs && !last_hs) idx_d = idx_q + 1'b1;
            if (last_hs) begin
                if (shd_full_q) begin
                    sreg_d = shd_q;
                    idx_d = '0;
                    shd_full_d = 1'b0;
                end else if (load) begin
                    sreg_d = p_in;
                    idx_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            // A load taken straight into sreg on an empty last lane bypasses the shadow
            if (load && !(last_hs && !shd_full_q)) begin
                if (!shd_full_q || last_hs) begin
                    shd_d = p_in;
                    shd_full_d = 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end
        end
        lane_d = sreg_d[idx_d*W +: W];
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sreg_q <= '0;
            shd_q <= '0;
            idx_q <= '0;
            shd_full_q <= 1'b0;
            v_q <= 1'b0;
            s_out_q <= '0;
            busy_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q <= sreg_d;
            shd_q <= shd_d;
            idx_q <= idx_d;
            shd_full_q <= shd_full_d;
            v_q <= state_d == SHIFT;
            s_out_q <= state_d == SHIFT ? lane_d : '0;
            busy_q <= (state_d == SHIFT) || shd_full_d;
            ovf_q <= ovf_d;
        end
    end
    assign s_out_v = v_q;
    assign s_out = s_out_q;
    assign busy = busy_q;
    assign overflow = ovf_q;
`ifdef RESULT_PISO_LAST_EN
    logic last_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) last_q <= 1'b0;
        else last_q <= (state_d == SHIFT) && (idx_d == LAST);
    end
    assign s_out_last = last_q;
`endif
endmodule

// File: tb/tb_result_piso.sv
// tb_result_piso: randomized + directed scoreboard bench for result_piso (PE_NUM=4, DATA_WIDTH=16).
module tb_result_piso;
    localparam int P = 4;
    localparam int DW = 16;
    localparam int W = 2*DW;
    logic clk = 1'b0, rst = 1'b0, load = 1'b0, s_out_ready = 1'b0;
    logic [P*W-1:0] p_in = '0;
    logic s_out_v, busy, overflow;
    logic [W-1:0] s_out;
`ifdef RESULT_PISO_LAST_EN
    logic s_out_last;
`endif
    result_piso #(.PE_NUM(P), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .load(load), .p_in(p_in), .s_out_ready(s_out_ready),
        .s_out_v(s_out_v), .s_out(s_out), .busy(busy), .overflow(overflow)
`ifdef RESULT_PISO_LAST_EN
        , .s_out_last(s_out_last)
`endif
    );
    always #5 clk = ~clk;
    int vectors = 0, miscompares = 0;
    logic [W-1:0] sb[$];
    int lanes = 0;
    logic exp_ovf = 1'b0;
    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    // Reference: a result is a block of P lanes; at most two results may be outstanding,
    // unless the front one hands over its final lane in the same cycle.
    always @(posedge clk or negedge rst) begin : model
        bit hs, front_last, accept;
        int pending;
        if (!rst) begin
            sb.delete();
            lanes = 0;
            exp_ovf = 1'b0;
        end else begin
            hs = lanes > 0 && s_out_ready;
            front_last = hs && (lanes % P == 1);
            pending = (lanes + P - 1) / P;
            accept = load && (pending < 2 || front_last);
            exp_ovf = load && !accept;
            if (hs) lanes--;
            if (accept) begin
                for (int k = 0; k < P; k++) sb.push_back(p_in[k*W +: W]);
                lanes += P;
            end
        end
    end
    logic prev_stall = 1'b0;
    logic [W-1:0] prev_out = '0;
    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_valid", W'(s_out_v), '0);
            chk("rst_busy", W'(busy), '0);
            chk("rst_out", s_out, '0);
            chk("rst_ovf", W'(overflow), '0);
            prev_stall = 1'b0;
        end else begin
            chk("valid", W'(s_out_v), W'(lanes > 0));
            chk("busy", W'(busy), W'(lanes > 0));
            chk("overflow", W'(overflow), W'(exp_ovf));
            if (!s_out_v) chk("idle_out_zero", s_out, '0);
            if (prev_stall) chk("stall_hold", s_out, prev_out);
`ifdef RESULT_PISO_LAST_EN
            chk("last", W'(s_out_last), W'(lanes > 0 && lanes % P == 1));
`endif
            if (s_out_v && s_out_ready) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL lane_unexpected: got %h expected no output at %0t", s_out, $time);
                end else begin
                    chk("lane", s_out, sb.pop_front());
                end
            end
            prev_stall = s_out_v && !s_out_ready;
            prev_out = s_out;
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic do_load(input logic [P*W-1:0] d);
        load = 1'b1;
        p_in = d;
        tick();
        load = 1'b0;
    endtask
    function automatic logic [P*W-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction
    localparam logic [P*W-1:0] SEQ = 128'h00000004_00000003_00000002_00000001;
    initial begin
        int n;
        repeat (3) tick();
        rst = 1'b1;
        repeat (20) tick();
        s_out_ready = 1'b1;
        do_load(SEQ);
        repeat (6) tick();
        do_load(SEQ);
        s_out_ready = 1'b0;
        repeat (4) tick();
        s_out_ready = 1'b1;
        repeat (6) tick();
        do_load(rnd_word());
        repeat (3) tick();
        do_load(rnd_word());
        repeat (9) tick();
        s_out_ready = 1'b0;
        do_load(rnd_word());
        do_load(rnd_word());
        do_load(rnd_word());
        repeat (3) tick();
        s_out_ready = 1'b1;
        repeat (10) tick();
        do_load(SEQ);
        tick();
        #2 rst = 1'b0;
        #1;
        chk("midrst_valid", W'(s_out_v), '0);
        chk("midrst_busy", W'(busy), '0);
        repeat (2) tick();
        rst = 1'b1;
        do_load(SEQ);
        repeat (6) tick();
        repeat (3000) begin
            load = ($urandom % 3) == 0;
            s_out_ready = ($urandom % 4) != 0;
            p_in = rnd_word();
            rst = ($urandom % 400) != 0;
            tick();
        end
        rst = 1'b1;
        load = 1'b0;
        s_out_ready = 1'b1;
        n = 0;
        while (lanes > 0 && n < 100) begin
            tick();
            n++;
        end
        tick();
        chk("drain_timeout", W'(lanes), '0);
        chk("scoreboard_empty", W'(sb.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/result_piso.md
# result_piso

Parallel-in/serial-out result unloader that sits directly downstream of the PE array. On `load` it captures the concatenated PE result word, one lane per PE, and streams the lanes out one per cycle over a valid/ready handshake. A one-deep shadow register lets the array present the next result while the current one is still draining.

## Interface
Parameters:
- `PE_NUM`, default `` `PE_NUM ``: number of lanes, i.e. PEs.
- `DATA_WIDTH`, default `` `DATA_WIDTH ``: width of one real component. A lane is `W = 2*DATA_WIDTH` bits (complex I/Q).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `load`  in  1  capture request for `p_in`. Single-cycle pulse or level; each high cycle is one capture.
- `p_in`  in  `PE_NUM*W`  lane k = `p_in[(k+1)*W-1 : k*W]`.
- `s_out_ready`  in  1  downstream can accept.
- `s_out_v`  out  1  `s_out` holds a valid lane.
- `s_out`  out  `W`  current lane. Registered.
- `busy`  out  1  shift register or shadow register occupied.
- `overflow`  out  1  one-cycle pulse when a capture is dropped.
- `s_out_last`  out  1  only with `RESULT_PISO_LAST_EN`; see Configuration.

## Operation
- Storage:
  - shift register `sreg`, `PE_NUM` lanes
  - lane index `idx`, width `$clog2(PE_NUM)`, minimum 1
  - shadow register `shd`, plus flag `shd_full`
- FSM states:
  - IDLE: `s_out_v=0`.
  - SHIFT: `s_out_v=1`, `s_out=sreg[idx]`.
- IDLE & `load`: `sreg<=p_in`, `idx<=0`, next state SHIFT.
- SHIFT, no handshake (`s_out_ready=0`): `s_out` and `idx` are held stable. `s_out_v` does not drop.
- SHIFT & handshake & `idx<PE_NUM-1`: `idx<=idx+1`.
- SHIFT & handshake & `idx==PE_NUM-1` (last lane):
  - If `shd_full`: `sreg<=shd`, `idx<=0`, `shd_full<=0`, stay in SHIFT. There is no bubble.
  - Else if `load` is high the same cycle: `sreg<=p_in`, `idx<=0`, stay in SHIFT.
  - Else: go to IDLE.
- `load` in SHIFT, excluding the last-lane case above:
  - If `!shd_full`: `shd<=p_in`, `shd_full<=1`.
  - If `shd_full`: the capture is dropped and `overflow` pulses high for 1 cycle. `sreg` and `shd` are unchanged.
- Simultaneous last-lane handshake, `shd_full=1` and `load`: `shd` moves to `sreg` and `p_in` goes into `shd`. No overflow.
- `busy = (state==SHIFT) | shd_full`.
- `s_out` is driven to 0 whenever `s_out_v=0`.
- Data is passed through bit-exact. No arithmetic is performed.

## Timing
- Reset values (async assert, sync release): state IDLE, `s_out_v=0`, `s_out=0`, `busy=0`, `overflow=0`, `s_out_last=0`, `idx=0`, `shd_full=0`. `sreg` and `shd` are don't-care.
- Latency: `load` at cycle T gives lane 0 on `s_out` with `s_out_v=1` at T+1.
- With `s_out_ready` held at 1: lane k appears at T+1+k. The last lane appears at T+`PE_NUM`.
- Sustained throughput: one `load` every `PE_NUM` cycles with ready=1 produces gap-free output and no overflow.
- `overflow` is asserted in the cycle after the dropped `load`.
- Reset asserted mid-stream: all outputs go to reset values immediately. Both the in-flight and the shadowed results are discarded.
- `PE_NUM=1`: every handshake is a last-lane handshake. Same rules apply.

## Configuration
- `RESULT_PISO_LAST_EN` defined:
  - Adds output `s_out_last`, which is high exactly while `s_out_v=1` and `idx==PE_NUM-1`.
  - Reset value is 0.
- Not defined: the port and its logic are absent. All other behaviour is identical.

## Test plan
All scenarios use `PE_NUM=4`, `DATA_WIDTH=16`.
- Reset then idle: hold `rst=0` for 3 cycles, release, no `load` → `s_out_v=0`, `s_out=0`, `busy=0` for 20 cycles.
- Single load, ready=1: `load` at T with `p_in=0x00000004_00000003_00000002_00000001` → `s_out` = 1, 2, 3, 4 at T+1..T+4. `s_out_v` falls at T+5. `s_out_last` is high at T+4 only (macro on).
- Backpressure: same load, `s_out_ready` low T+2..T+5 → `s_out` holds 2 with `s_out_v=1` during the stall. Full sequence 1, 2, 3, 4 is delivered with no duplicate or skipped lane.
- Back-to-back loads: loads at T and T+4 with lanes A0..A3 / B0..B3, ready=1 → 8 contiguous valid cycles A0..A3, B0..B3. `overflow` never pulses.
- Overflow: ready=0, loads at T, T+1, T+2 → third load is dropped and `overflow=1` at T+3 only. After ready rises, exactly 8 lanes come out, from the first two loads.
- Mid-stream reset: `rst=0` at T+2 of a transfer → `s_out_v=0` and `busy=0` immediately. After release, a new `load` streams correctly from lane 0.
